// File: rtl/des_search_pkg.sv
// Shared widths and types for the code-breaker key-search datapath.
package des_search_pkg;

   localparam int unsigned KEY_W = 56;
   localparam int unsigned CT_W  = 64;

   typedef logic [KEY_W-1:0] key_t;
   typedef logic [CT_W-1:0]  ct_t;

endpackage : des_search_pkg

// File: rtl/key_range_counter.sv
// Candidate-key counter: loads a search range, steps through it modulo
// 2^KEY_W (so a range with end < start runs through the wrap), and flags
// when the current key is the inclusive last key of the range.
module key_range_counter
   import des_search_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [KEY_W-1:0] start_key,
   input  logic [KEY_W-1:0] end_key,
   input  logic             advance,
   output logic [KEY_W-1:0] key,
   output logic             at_end
);

   key_t end_q;

   assign at_end = (key == end_q);

   // Range register and counter; load wins, advance stops on the last key.
   always_ff @(posedge clk) begin
      if (reset) begin
         key   <= '0;
         end_q <= '0;
      end else if (load) begin
         key   <= start_key;
         end_q <= end_key;
      end else if (advance && !at_end) begin
         key   <= key + key_t'(1);
      end
   end

endmodule : key_range_counter

// File: rtl/key_search_datapath.sv
// Key-search datapath for the code breaker. Takes the control FSM's
// up/en1/en2 strobes, drives the candidate key to an external
// combinational DES core, compares the returned ciphertext with the
// target and captures the matching key.
// Optional trial counter enabled by defining TRIAL_CNT_EN; otherwise
// trials reads as zero and no counter is built.
module key_search_datapath
   import des_search_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [KEY_W-1:0] start_key,
   input  logic [KEY_W-1:0] end_key,
   input  logic [CT_W-1:0]  target_ct,
   input  logic             up,
   input  logic             en1,
   input  logic             en2,
   input  logic [CT_W-1:0]  des_ct,
   output logic [KEY_W-1:0] key,
   output logic             found,
   output logic             exhausted,
   output logic [KEY_W-1:0] result_key,
   output logic             result_valid,
   output logic [31:0]      trials
);

   ct_t  target_q;
   logic armed;
   logic at_end;
   logic advance;
   logic capture;

   // found feeds the FSM's store state in the same cycle, so it stays combinational.
   assign found = armed & en1 & (des_ct == target_q) & ~exhausted;

   // en2 is the found-key hold: nothing moves while it is asserted.
   assign advance = up & armed & ~result_valid & ~exhausted & ~en2;
   assign capture = found & ~en2;

   key_range_counter u_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .start_key (start_key),
      .end_key   (end_key),
      .advance   (advance),
      .key       (key),
      .at_end    (at_end)
   );

   // Search state: target, arming, exhaustion and result capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         target_q     <= '0;
         armed        <= 1'b0;
         exhausted    <= 1'b0;
         result_key   <= '0;
         result_valid <= 1'b0;
      end else if (load) begin
         target_q     <= target_ct;
         armed        <= 1'b1;
         exhausted    <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         if (advance && at_end) begin
            exhausted <= 1'b1;
         end
         if (capture) begin
            result_key   <= key;
            result_valid <= 1'b1;
         end
      end
   end

`ifdef TRIAL_CNT_EN
   // Saturating count of candidates evaluated in the current range.
   always_ff @(posedge clk) begin
      if (reset || load) begin
         trials <= '0;
      end else if (en1 && armed && !exhausted && (trials != '1)) begin
         trials <= trials + 32'd1;
      end
   end
`else
   assign trials = '0;
`endif

endmodule : key_search_datapath

// File: tb/tb_key_search_datapath.sv
// Scoreboard bench for key_search_datapath. Each stimulus step drives the
// inputs just after a rising edge and queues the outputs expected at the
// following falling edge; a monitor pops and compares there.
module tb_key_search_datapath;

   localparam logic [63:0] C = 64'hA5A5_5A5A_0F0F_F0F0;

   typedef struct {
      logic [55:0] key;
      logic        found;
      logic        exh;
      logic [55:0] rkey;
      logic        rvalid;
      logic [31:0] trials;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load;
   logic [55:0] start_key;
   logic [55:0] end_key;
   logic [63:0] target_ct;
   logic        up;
   logic        en1;
   logic        en2;
   logic [63:0] des_ct;
   logic [55:0] key;
   logic        found;
   logic        exhausted;
   logic [55:0] result_key;
   logic        result_valid;
   logic [31:0] trials;

   exp_t exp_q[$];
   logic chk;
   int   checks;
   int   failures;
   int   step_no;

   // Stand-in DES core: a fixed XOR of the zero-extended key, combinational.
   assign des_ct = {8'h00, key} ^ C;

   key_search_datapath dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .start_key    (start_key),
      .end_key      (end_key),
      .target_ct    (target_ct),
      .up           (up),
      .en1          (en1),
      .en2          (en2),
      .des_ct       (des_ct),
      .key          (key),
      .found        (found),
      .exhausted    (exhausted),
      .result_key   (result_key),
      .result_valid (result_valid),
      .trials       (trials)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] tg(input logic [55:0] k);
      return {8'h00, k} ^ C;
   endfunction

   function automatic logic [31:0] tr(input int unsigned n);
`ifdef TRIAL_CNT_EN
      return 32'(n);
`else
      return (n == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic cmp(input string nm, input int s, input logic [63:0] act, input logic [63:0] ex);
      checks++;
      if (act !== ex) begin
         failures++;
         $display("FAIL step%0d %s: got %h expected %h", s, nm, act, ex);
      end
   endtask

   // Monitor: pops one expectation per requested sample point and compares.
   always @(negedge clk) begin
      if (chk) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL step%0d scoreboard: got empty queue expected an entry", step_no);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("key",          step_no, 64'(key),          64'(e.key));
            cmp("found",        step_no, 64'(found),        64'(e.found));
            cmp("exhausted",    step_no, 64'(exhausted),    64'(e.exh));
            cmp("result_key",   step_no, 64'(result_key),   64'(e.rkey));
            cmp("result_valid", step_no, 64'(result_valid), 64'(e.rvalid));
            cmp("trials",       step_no, 64'(trials),       64'(e.trials));
         end
      end
   end

   // One cycle of stimulus; the expectation describes the state left by the
   // previous step's inputs plus found for this step's inputs.
   task automatic step(input logic rs, input logic ld, input logic [55:0] sk, input logic [55:0] ek,
                       input logic [63:0] tct, input logic u, input logic e1, input logic e2,
                       input logic [55:0] xkey, input logic xf, input logic xexh,
                       input logic [55:0] xrk, input logic xrv, input logic [31:0] xtr);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rs;
      load      = ld;
      start_key = sk;
      end_key   = ek;
      target_ct = tct;
      up        = u;
      en1       = e1;
      en2       = e2;
      e.key = xkey; e.found = xf; e.exh = xexh; e.rkey = xrk; e.rvalid = xrv; e.trials = xtr;
      exp_q.push_back(e);
      step_no++;
      chk = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0; step_no = 0; chk = 1'b0;
      reset = 1'b1; load = 1'b0; start_key = '0; end_key = '0; target_ct = '0;
      up = 1'b0; en1 = 1'b0; en2 = 1'b0;

      //   rs ld start              end        target       up e1 e2 | key               f  exh rkey  rv trials
      // Reset state, then basic hit at 0x13
      step(1, 0, 56'h0,  56'h0,  64'h0,      0, 0, 0,  56'h0,  0, 0, 56'h0,  0, tr(0));
      step(0, 1, 56'h10, 56'hFF, tg(56'h13), 0, 0, 0,  56'h0,  0, 0, 56'h0,  0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h10, 0, 0, 56'h0,  0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h10, 0, 0, 56'h0,  0, tr(1));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h11, 0, 0, 56'h0,  0, tr(1));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h11, 0, 0, 56'h0,  0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h12, 0, 0, 56'h0,  0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h12, 0, 0, 56'h0,  0, tr(3));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h13, 1, 0, 56'h0,  0, tr(3));
      // Freeze: en2 with stray up for five cycles
      for (int i = 0; i < 5; i++)
         step(0, 0, 56'h0, 56'h0, 64'h0,     1, 0, 1,  56'h13, 0, 0, 56'h13, 1, tr(4));
      // Reload clears result_valid and trials
      step(0, 1, 56'h40, 56'h50, tg(56'h45), 0, 0, 0,  56'h13, 0, 0, 56'h13, 1, tr(4));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 0, 0,  56'h40, 0, 0, 56'h13, 0, tr(0));
      // Priority: load with up in the same cycle
      step(0, 1, 56'h5,  56'h9,  tg(56'h13), 1, 0, 0,  56'h40, 0, 0, 56'h13, 0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 0, 0,  56'h5,  0, 0, 56'h13, 0, tr(0));
      // Exhaustion over 0x20..0x22; target 0x22 is only offered after exhaustion
      step(0, 1, 56'h20, 56'h22, tg(56'h22), 0, 0, 0,  56'h5,  0, 0, 56'h13, 0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h20, 0, 0, 56'h13, 0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h20, 0, 0, 56'h13, 0, tr(1));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h21, 0, 0, 56'h13, 0, tr(1));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h21, 0, 0, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h22, 0, 0, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h22, 0, 1, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h22, 0, 1, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 0, 0,  56'h22, 0, 1, 56'h13, 0, tr(2));
      // Wrap-around range, match at 0
      step(0, 1, 56'hFF_FFFF_FFFF_FFFE, 56'h1, tg(56'h0), 0, 0, 0, 56'h22, 0, 1, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'hFF_FFFF_FFFF_FFFE, 0, 0, 56'h13, 0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'hFF_FFFF_FFFF_FFFE, 0, 0, 56'h13, 0, tr(1));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'hFF_FFFF_FFFF_FFFF, 0, 0, 56'h13, 0, tr(1));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'hFF_FFFF_FFFF_FFFF, 0, 0, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 1, 0,  56'h0,  1, 0, 56'h13, 0, tr(2));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 0, 0,  56'h0,  0, 0, 56'h0,  1, tr(3));
      // Reset mid-search, then up without load stays at 0
      step(0, 1, 56'h30, 56'h3F, tg(56'h13), 0, 0, 0,  56'h0,  0, 0, 56'h0,  1, tr(3));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h30, 0, 0, 56'h0,  0, tr(0));
      step(1, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h31, 0, 0, 56'h0,  0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 0, 0,  56'h0,  0, 0, 56'h0,  0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      1, 1, 0,  56'h0,  0, 0, 56'h0,  0, tr(0));
      step(0, 0, 56'h0,  56'h0,  64'h0,      0, 0, 0,  56'h0,  0, 0, 56'h0,  0, tr(0));

      @(posedge clk);
      #1;
      chk = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_key_search_datapath
